// File: rtl/bfp_pkg.sv
// Shared types and constants for the BFP PRB unpacker.
package bfp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXP,
    S_DATA,
    S_TERM
  } bfp_state_t;

  localparam int BFP_EXP_BITS         = 8;
  localparam int BFP_WORDS_PER_PRB    = 6;
  localparam int BFP_SAMPLES_PER_WORD = 4;

  // Bits per output word for sample width w; w=0 means uncompressed 16-bit.
  function automatic logic [6:0] width_bits(input logic [3:0] w);
    if (w == 4'd0) return 7'd64;
    return 7'(BFP_SAMPLES_PER_WORD) * {3'b000, w};
  endfunction

endpackage

// File: rtl/bfp_bit_gearbox.sv
// 128-bit MSB-first bit buffer: appends whole kept bytes, pops up to 64 bits from the head.
module bfp_bit_gearbox (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic [7:0]  push_keep,
  input  logic        pop,
  input  logic [6:0]  pop_bits,
  output logic [7:0]  fill,
  output logic [63:0] head
);

  logic [127:0] bits_q, bits_d;
  logic [7:0]   fill_q, fill_d;
  logic [63:0]  beat_msb;
  logic [3:0]   nbytes;
  logic [7:0]   popped;
  logic [7:0]   kept;

  // Byte 0 of the beat is the first on the wire, so it lands in the top byte.
  always_comb begin
    beat_msb = '0;
    nbytes   = '0;
    for (int i = 0; i < 8; i++) begin
      if (push_keep[i]) begin
        beat_msb[63-8*i -: 8] = push_data[8*i +: 8];
        nbytes = nbytes + 4'd1;
      end
    end
  end

  // Unused bits below the fill level are kept zero so the append can simply OR in.
  always_comb begin
    popped = pop ? {1'b0, pop_bits} : 8'd0;
    kept   = fill_q - popped;
    bits_d = bits_q << popped;
    fill_d = kept;
    if (push) begin
      bits_d = bits_d | ({beat_msb, 64'd0} >> kept);
      fill_d = kept + {1'b0, nbytes, 3'b000};
    end
    if (clear) begin
      bits_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign head = bits_q[127:64];

endmodule

// File: rtl/bfp_decomp_unpack.sv
// Re-slices a byte-packed BFP PRB stream into 4-sample words tagged with the PRB exponent.
// Optional BFP_UNPACK_STAT_EN adds saturating PRB and truncation counters.
//
// state  | meaning
// S_IDLE | waiting for the first beat of a packet
// S_EXP  | waiting to pop the udCompParam exponent byte
// S_DATA | popping 4W-bit words, cnt = word index within the PRB
// S_TERM | packet ended mid-PRB; emit a zero terminating word
module bfp_decomp_unpack
  import bfp_pkg::*;
#(
  parameter int USER_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cfg_width,
  input  logic [63:0]       s_axis_tdata,
  input  logic [7:0]        s_axis_tkeep,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [USER_W-1:0] s_axis_tuser,
  output logic [3:0]        din_width,
  output logic [63:0]       din_data,
  output logic              din_valid,
  output logic              din_last,
  output logic [USER_W-1:0] din_user,
  output logic              err_trunc
`ifdef BFP_UNPACK_STAT_EN
  ,
  output logic [31:0]       stat_prb_cnt,
  output logic [15:0]       stat_err_cnt
`endif
);

  bfp_state_t        state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic [3:0]        exp_q, exp_d;
  logic [3:0]        width_q;
  logic [USER_W-1:0] user_q;
  logic              tlast_seen;

  logic [7:0]  fill;
  logic [63:0] head;
  logic [6:0]  need;
  logic        have;
  logic        accept;
  logic        pop, clear, word_vld, word_last, term;
  logic [63:0] word;

  assign need   = (state == S_EXP) ? 7'(BFP_EXP_BITS) : width_bits(width_q);
  assign have   = fill >= {1'b0, need};
  assign s_axis_tready = !rst && (fill <= 8'd64) && (state != S_TERM) && !tlast_seen;
  assign accept = s_axis_tvalid && s_axis_tready;

  bfp_bit_gearbox u_gearbox (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (accept),
    .push_data (s_axis_tdata),
    .push_keep (s_axis_tkeep),
    .pop       (pop),
    .pop_bits  (need),
    .fill      (fill),
    .head      (head)
  );

  always_comb begin
    if (width_q == 4'd0) word = head;
    else                 word = (head >> (7'd64 - need)) | ({60'd0, exp_q} << need);
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    exp_d     = exp_q;
    pop       = 1'b0;
    word_vld  = 1'b0;
    word_last = 1'b0;
    term      = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          state_d = (cfg_width == 4'd0) ? S_DATA : S_EXP;
          cnt_d   = '0;
        end
      end
      S_EXP: begin
        if (have) begin
          pop     = 1'b1;
          exp_d   = head[59:56];
          cnt_d   = '0;
          state_d = S_DATA;
        end else if (tlast_seen) begin
          state_d = S_TERM;
        end
      end
      S_DATA: begin
        if (have) begin
          pop      = 1'b1;
          word_vld = 1'b1;
          if (cnt == 3'(BFP_WORDS_PER_PRB - 1)) begin
            cnt_d = '0;
            // tready is low once tlast is absorbed, so fill==need means nothing follows
            if (tlast_seen && (fill == {1'b0, need})) begin
              word_last = 1'b1;
              clear     = 1'b1;
              state_d   = S_IDLE;
            end else if (width_q != 4'd0) begin
              state_d = S_EXP;
            end
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end else if (tlast_seen) begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        term    = 1'b1;
        clear   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      exp_q      <= '0;
      width_q    <= '0;
      user_q     <= '0;
      tlast_seen <= 1'b0;
      din_valid  <= 1'b0;
      din_last   <= 1'b0;
      din_data   <= '0;
      err_trunc  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      exp_q <= exp_d;
      if (clear) tlast_seen <= 1'b0;
      else if (accept && s_axis_tlast) tlast_seen <= 1'b1;
      if (state == S_IDLE && accept) begin
        width_q <= cfg_width;
        user_q  <= s_axis_tuser;
      end
      din_valid <= word_vld | term;
      din_last  <= word_last | term;
      err_trunc <= term;
      if (term) din_data <= '0;
      else if (word_vld) din_data <= word;
    end
  end

  assign din_width = width_q;
  assign din_user  = user_q;

`ifdef BFP_UNPACK_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_prb_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (word_vld && cnt == 3'(BFP_WORDS_PER_PRB - 1) && stat_prb_cnt != '1)
        stat_prb_cnt <= stat_prb_cnt + 32'd1;
      if (term && stat_err_cnt != '1)
        stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bfp_decomp_unpack.sv
// Directed bench for bfp_decomp_unpack: byte-level reference model plus literal spot checks.
// Build with +define+BFP_UNPACK_STAT_EN to also check the statistics counters.
module tb_bfp_decomp_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_width = '0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] s_axis_tuser = '0;
  logic [3:0]  din_width;
  logic [63:0] din_data;
  logic        din_valid;
  logic        din_last;
  logic [31:0] din_user;
  logic        err_trunc;
`ifdef BFP_UNPACK_STAT_EN
  logic [31:0] stat_prb_cnt;
  logic [15:0] stat_err_cnt;
`endif

  bfp_decomp_unpack #(.USER_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_width     (cfg_width),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .din_width     (din_width),
    .din_data      (din_data),
    .din_valid     (din_valid),
    .din_last      (din_last),
    .din_user      (din_user),
    .err_trunc     (err_trunc)
`ifdef BFP_UNPACK_STAT_EN
    ,
    .stat_prb_cnt  (stat_prb_cnt),
    .stat_err_cnt  (stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
    logic [3:0]  width;
    logic [31:0] user;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  pkt[$];
  logic [63:0] got_log[$];
  int          got_cyc[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          model_prbs = 0;
  int          model_errs = 0;
  bit          check_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // Reference: walk the packet as a bit string, PRB by PRB.
  task automatic model_packet(input int w, input logic [31:0] user);
    int nbits, pos, n;
    logic [3:0] e;
    logic [63:0] s;
    exp_t ex;
    bit done;
    nbits = pkt.size() * 8;
    pos = 0;
    n = (w == 0) ? 64 : 4 * w;
    e = '0;
    done = 1'b0;
    ex.width = 4'(w);
    ex.user = user;
    while (!done) begin
      if (w != 0) begin
        if (pos + 8 > nbits) begin
          ex.data = '0; ex.last = 1'b1; ex.err = 1'b1;
          expq.push_back(ex); model_errs++; done = 1'b1;
        end else begin
          e = pkt[pos/8][3:0];
          pos += 8;
        end
      end
      for (int k = 0; k < 6 && !done; k++) begin
        if (pos + n > nbits) begin
          ex.data = '0; ex.last = 1'b1; ex.err = 1'b1;
          expq.push_back(ex); model_errs++; done = 1'b1;
        end else begin
          s = '0;
          for (int b = 0; b < n; b++) s = {s[62:0], pkt[(pos+b)/8][7-((pos+b)%8)]};
          pos += n;
          ex.data = (w == 0) ? s : (s | (64'(e) << n));
          ex.last = (k == 5) && (pos == nbits);
          ex.err  = 1'b0;
          expq.push_back(ex);
          if (k == 5) model_prbs++;
          if (ex.last) done = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (!rst && check_en) begin
      if (din_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", din_data, 64'hx);
        end else begin
          ex = expq.pop_front();
          chk("din_data", din_data, ex.data);
          chk("din_last", 64'(din_last), 64'(ex.last));
          chk("err_trunc", 64'(err_trunc), 64'(ex.err));
          chk("din_width", 64'(din_width), 64'(ex.width));
          chk("din_user", 64'(din_user), 64'(ex.user));
        end
        got_log.push_back(din_data);
        got_cyc.push_back(cyc);
      end else begin
        chk("stray_pulse", 64'(din_last | err_trunc), 64'd0);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int t;
    t = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && t < 300) begin
      @(negedge clk); #1; t++; stalls++;
    end
    if (!s_axis_tready) chk("ready_timeout", 64'(s_axis_tready), 64'd1);
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_packet(input int w, input logic [31:0] user);
    int n, nb;
    logic [63:0] d;
    logic [7:0] k;
    n = pkt.size();
    nb = (n + 7) / 8;
    model_packet(w, user);
    cfg_width = 4'(w);
    s_axis_tuser = user;
    for (int b = 0; b < nb; b++) begin
      d = '0; k = '0;
      for (int j = 0; j < 8; j++) begin
        if (b*8 + j < n) begin
          d[8*j +: 8] = pkt[b*8 + j];
          k[j] = 1'b1;
        end
      end
      send_beat(d, k, b == nb - 1);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 500) begin
      @(negedge clk); t++;
    end
    chk("drain", 64'(expq.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic make_prb_w8(input logic [3:0] e, input int ndata);
    pkt.delete();
    pkt.push_back({4'hA, e});
    for (int i = 0; i < ndata; i++) pkt.push_back(8'(i));
  endtask

  initial begin
    #3;
    chk("rst_din_valid", 64'(din_valid), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_din_data", din_data, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    // W=8 clean PRB: exponent 5 followed by bytes 0x00..0x17
    pkt.delete();
    pkt.push_back(8'h05);
    for (int i = 0; i < 24; i++) pkt.push_back(8'(i));
    got_log.delete();
    send_packet(8, 32'h1111_0008);
    wait_drain();
    chk("w8_count", 64'(got_log.size()), 64'd6);
    if (got_log.size() == 6) begin
      chk("w8_word0", got_log[0], 64'h5_0001_0203);
      chk("w8_word5", got_log[5], 64'h5_1415_1617);
    end

    // W=0: two PRBs as 12 full beats, must stream at one word per clock
    pkt.delete();
    for (int i = 0; i < 96; i++) pkt.push_back(8'(i));
    got_log.delete(); got_cyc.delete();
    stalls = 0;
    send_packet(0, 32'h2222_0000);
    chk("w0_stalls", 64'(stalls), 64'd0);
    wait_drain();
    chk("w0_count", 64'(got_log.size()), 64'd12);
    if (got_log.size() == 12) begin
      chk("w0_word0", got_log[0], 64'h0001_0203_0405_0607);
      chk("w0_span", 64'(got_cyc[11] - got_cyc[0]), 64'd11);
    end

    // W=9: 28 bytes, words straddle byte boundaries
    pkt.delete();
    pkt.push_back(8'h03);
    for (int i = 0; i < 27; i++) pkt.push_back(8'(i));
    got_log.delete();
    send_packet(9, 32'h3333_0009);
    wait_drain();
    chk("w9_count", 64'(got_log.size()), 64'd6);
    if (got_log.size() == 6) begin
      chk("w9_word0", got_log[0], 64'h30_0010_2030);
      chk("w9_word1", got_log[1], 64'h34_0506_0708);
    end

    // Reset in the middle of a W=8 PRB after 10 bytes
    check_en = 1'b0;
    expq.delete();
    make_prb_w8(4'h7, 7);
    cfg_width = 4'd8;
    s_axis_tuser = 32'hDEAD_BEEF;
    send_beat({pkt[7], pkt[6], pkt[5], pkt[4], pkt[3], pkt[2], pkt[1], pkt[0]}, 8'hFF, 1'b0);
    send_beat({48'd0, 8'h55, 8'h44}, 8'h03, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_din_valid", 64'(din_valid), 64'd0);
    chk("arst_din_width", 64'(din_width), 64'd0);
    chk("arst_din_user", 64'(din_user), 64'd0);
    chk("arst_din_data", din_data, 64'd0);
    chk("arst_tready", 64'(s_axis_tready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_prbs = 0; model_errs = 0;
    check_en = 1'b1;
    @(negedge clk);
    make_prb_w8(4'h6, 24);
    got_log.delete();
    send_packet(8, 32'h4444_0008);
    wait_drain();
    chk("post_rst_count", 64'(got_log.size()), 64'd6);
    if (got_log.size() == 6) chk("post_rst_word0", got_log[0], 64'h6_0001_0203);

    // Truncated W=8 packet: 20 bytes gives 4 words then a terminating word
    make_prb_w8(4'h2, 19);
    got_log.delete();
    send_packet(8, 32'h5555_0008);
    wait_drain();
    chk("trunc_count", 64'(got_log.size()), 64'd5);
    if (got_log.size() == 5) chk("trunc_term_data", got_log[4], 64'd0);

    // Three clean PRBs after the truncation, the first with W=9
    pkt.delete();
    pkt.push_back(8'h0C);
    for (int i = 0; i < 27; i++) pkt.push_back(8'(8'hF0 - 8'(i)));
    send_packet(9, 32'h6666_0009);
    wait_drain();
    make_prb_w8(4'hF, 24);
    send_packet(8, 32'h7777_0008);
    wait_drain();
    pkt.delete();
    pkt.push_back(8'h01);
    for (int i = 0; i < 12; i++) pkt.push_back(8'(8'h3C + 8'(i)));
    send_packet(4, 32'h8888_0004);
    wait_drain();

`ifdef BFP_UNPACK_STAT_EN
    chk("stat_prb_cnt", 64'(stat_prb_cnt), 64'(model_prbs));
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'(model_errs));
    chk("stat_err_lit", 64'(stat_err_cnt), 64'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks want completion", total);
    $fatal(1, "timeout");
  end

endmodule
